// File: rtl/frame_word_packer.sv
// frame_word_packer: packs one RX port's post-SFD byte stream into words
// and fans each word out to every switch port except its own.
module frame_word_packer #(
    parameter int pDATA_WIDTH     = 8,
    parameter int pBYTES_PER_WORD = 4,
    parameter int pPORT_NUM       = 4,
    parameter int pSRC_PORT       = 0,
    parameter int pMAX_WORDS      = 384
) (
    input  logic                                   i_clk,
    input  logic                                   i_rst_n,
    input  logic [pDATA_WIDTH-1:0]                 i_data,
    input  logic                                   i_byte_valid,
    input  logic                                   i_sof,
    input  logic                                   i_eof,
    input  logic                                   i_rx_er,
    input  logic                                   i_dst_valid,
    input  logic [pPORT_NUM-1:0]                   i_dst_mask,
    output logic [pBYTES_PER_WORD*pDATA_WIDTH-1:0] o_data,
    output logic [pPORT_NUM-1:0]                   o_valid,
    output logic                                   o_sop,
    output logic                                   o_eop,
    output logic [$clog2(pBYTES_PER_WORD)-1:0]     o_empty,
    output logic [pPORT_NUM-1:0]                   o_delete,
    output logic [15:0]                            o_abort_cnt
);

    localparam int LW = $clog2(pBYTES_PER_WORD);
    localparam int WW = pBYTES_PER_WORD * pDATA_WIDTH;
    localparam int CW = $clog2(pMAX_WORDS + 1);
    localparam logic [pPORT_NUM-1:0] SRC_MASK =
        {{(pPORT_NUM-1){1'b0}}, 1'b1} << pSRC_PORT;
    localparam logic [pPORT_NUM-1:0] EN_INIT = ~SRC_MASK;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PACK,
        S_DISCARD
    } state_t;

    state_t               state, state_n;
    logic [LW-1:0]        lane, lane_n, lane_b;
    logic [CW-1:0]        wcnt, wcnt_n, wcnt_b;
    logic [pPORT_NUM-1:0] en, en_n;
    logic [pPORT_NUM-1:0] sent, sent_n, sent_b;
    logic [WW-1:0]        word_q, word_n, word_b, word_w;
    logic [WW-1:0]        data_n;
    logic [pPORT_NUM-1:0] del_n;
    logic [LW-1:0]        empty_n;
    logic                 sop_n, eop_n;
    logic                 start, take, abort, emit, max_hit;

    // Next state, lane fill, mask pruning and word emission.
    always_comb begin
        state_n = state;
        lane_n  = lane;
        wcnt_n  = wcnt;
        en_n    = en;
        sent_n  = sent;
        word_n  = word_q;
        lane_b  = lane;
        wcnt_b  = wcnt;
        sent_b  = sent;
        word_b  = word_q;
        word_w  = word_q;
        data_n  = o_data;
        del_n   = '0;
        empty_n = '0;
        sop_n   = 1'b0;
        eop_n   = 1'b0;
        start   = 1'b0;
        take    = 1'b0;
        abort   = 1'b0;
        emit    = 1'b0;
        max_hit = i_byte_valid && (wcnt == CW'(pMAX_WORDS));

        unique case (state)
            S_IDLE, S_DISCARD: begin
                if (i_byte_valid && i_sof) begin
                    start = 1'b1;
                    take  = 1'b1;
                end else if (state == S_DISCARD && i_byte_valid && i_eof) begin
                    state_n = S_IDLE;
                end
            end
            S_PACK: begin
                if (i_rx_er || max_hit || (i_byte_valid && i_sof)) begin
                    abort  = 1'b1;
                    del_n  = en & sent;
                    en_n   = '0;
                    sent_n = '0;
                    lane_n = '0;
                    wcnt_n = '0;
                    word_n = '0;
                    if (i_byte_valid && i_eof) begin
                        state_n = S_IDLE;
                    end else if (i_rx_er || max_hit) begin
                        state_n = S_DISCARD;
                    end else begin
                        start = 1'b1;
                        take  = 1'b1;
                    end
                end else begin
                    if (i_dst_valid) begin
                        en_n  = en & i_dst_mask & ~SRC_MASK;
                        del_n = en & ~en_n & sent;
                        if (en_n == '0) state_n = S_DISCARD;
                    end
                    take = i_byte_valid;
                end
            end
            default: state_n = S_IDLE;
        endcase

        // A new frame always lands in lane 0 of an all-zero word.
        if (start) begin
            lane_b  = '0;
            wcnt_b  = '0;
            sent_b  = '0;
            word_b  = '0;
            en_n    = EN_INIT;
            state_n = S_PACK;
        end

        if (take) begin
            word_w = word_b;
            for (int k = 0; k < pBYTES_PER_WORD; k++) begin
                if (lane_b == LW'(k))
                    word_w[(pBYTES_PER_WORD-k)*pDATA_WIDTH-1 -: pDATA_WIDTH] = i_data;
            end
            if ((&lane_b) || i_eof) begin
                emit    = 1'b1;
                data_n  = word_w;
                sop_n   = (wcnt_b == '0);
                eop_n   = i_eof;
                // Lanes beyond lane_b are unused; ~lane_b == BPW-1-lane_b.
                empty_n = i_eof ? ~lane_b : '0;
                sent_n  = sent_b | en_n;
                lane_n  = '0;
                word_n  = '0;
                wcnt_n  = (&lane_b) ? wcnt_b + CW'(1) : wcnt_b;
                if (i_eof) state_n = S_IDLE;
            end else begin
                word_n = word_w;
                lane_n = lane_b + LW'(1);
                wcnt_n = wcnt_b;
                sent_n = sent_b;
            end
        end
    end

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= S_IDLE;
        else          state <= state_n;
    end

    // Datapath registers and output strobes.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            lane        <= '0;
            wcnt        <= '0;
            en          <= '0;
            sent        <= '0;
            word_q      <= '0;
            o_data      <= '0;
            o_valid     <= '0;
            o_sop       <= 1'b0;
            o_eop       <= 1'b0;
            o_empty     <= '0;
            o_delete    <= '0;
            o_abort_cnt <= '0;
        end else begin
            lane     <= lane_n;
            wcnt     <= wcnt_n;
            en       <= en_n;
            sent     <= sent_n;
            word_q   <= word_n;
            o_data   <= data_n;
            o_valid  <= emit ? en_n : '0;
            o_sop    <= emit & sop_n;
            o_eop    <= emit & eop_n;
            o_empty  <= emit ? empty_n : '0;
            o_delete <= del_n;
            if (abort && o_abort_cnt != 16'hFFFF)
                o_abort_cnt <= o_abort_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_frame_word_packer.sv
// tb_frame_word_packer: directed frames against hand-computed words,
// strobes, delete pulses and abort counts.
module tb_frame_word_packer;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic [7:0]  i_data = '0;
    logic        i_byte_valid = 1'b0;
    logic        i_sof = 1'b0;
    logic        i_eof = 1'b0;
    logic        i_rx_er = 1'b0;
    logic        i_dst_valid = 1'b0;
    logic [3:0]  i_dst_mask = '0;

    logic [31:0] o_data, m_data;
    logic [3:0]  o_valid, m_valid;
    logic        o_sop, o_eop, m_sop, m_eop;
    logic [1:0]  o_empty, m_empty;
    logic [3:0]  o_delete, m_delete;
    logic [15:0] o_abort_cnt, m_abort;

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  v;
        logic        s;
        logic        e;
        logic [1:0]  m;
    } wrec_t;

    wrec_t      q_w[$];
    wrec_t      mq_w[$];
    logic [3:0] q_del[$];
    logic [3:0] mq_del[$];

    int n_chk = 0;
    int n_err = 0;

    always #5 i_clk = ~i_clk;

    frame_word_packer dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_data(i_data),
        .i_byte_valid(i_byte_valid), .i_sof(i_sof), .i_eof(i_eof),
        .i_rx_er(i_rx_er), .i_dst_valid(i_dst_valid),
        .i_dst_mask(i_dst_mask), .o_data(o_data), .o_valid(o_valid),
        .o_sop(o_sop), .o_eop(o_eop), .o_empty(o_empty),
        .o_delete(o_delete), .o_abort_cnt(o_abort_cnt)
    );

    frame_word_packer #(.pMAX_WORDS(8)) dut_m (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_data(i_data),
        .i_byte_valid(i_byte_valid), .i_sof(i_sof), .i_eof(i_eof),
        .i_rx_er(i_rx_er), .i_dst_valid(i_dst_valid),
        .i_dst_mask(i_dst_mask), .o_data(m_data), .o_valid(m_valid),
        .o_sop(m_sop), .o_eop(m_eop), .o_empty(m_empty),
        .o_delete(m_delete), .o_abort_cnt(m_abort)
    );

    // Capture emitted words and delete pulses away from the active edge.
    always @(negedge i_clk) begin
        if (i_rst_n) begin
            if (|o_valid) q_w.push_back({o_data, o_valid, o_sop, o_eop, o_empty});
            if (|o_delete) q_del.push_back(o_delete);
            if (|m_valid) mq_w.push_back({m_data, m_valid, m_sop, m_eop, m_empty});
            if (|m_delete) mq_del.push_back(m_delete);
        end
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic wrec_t w(input int i);
        if (i < q_w.size()) return q_w[i];
        return 'x;
    endfunction

    function automatic wrec_t mw(input int i);
        if (i < mq_w.size()) return mq_w[i];
        return 'x;
    endfunction

    function automatic logic [3:0] dl(input int i);
        if (i < q_del.size()) return q_del[i];
        return 'x;
    endfunction

    function automatic logic [3:0] mdl(input int i);
        if (i < mq_del.size()) return mq_del[i];
        return 'x;
    endfunction

    // Expected word wi of a frame whose byte b is st + step*b, n bytes long.
    function automatic logic [31:0] ew(input int st, input int step,
                                       input int wi, input int n);
        logic [31:0] r;
        r = '0;
        for (int j = 0; j < 4; j++) begin
            int b;
            b = wi * 4 + j;
            if (b < n) r[31-8*j -: 8] = 8'(st + step * b);
        end
        return r;
    endfunction

    task automatic drv(input logic [7:0] d, input logic v, input logic sof,
                       input logic eof, input logic er, input logic dv,
                       input logic [3:0] m);
        @(negedge i_clk);
        i_data       = d;
        i_byte_valid = v;
        i_sof        = sof;
        i_eof        = eof;
        i_rx_er      = er;
        i_dst_valid  = dv;
        i_dst_mask   = m;
    endtask

    task automatic idle(input int n);
        repeat (n) drv(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0);
    endtask

    task automatic frame(input int st, input int n, input int step = 1,
                         input int er_at = -1, input int dv_at = -1,
                         input logic [3:0] m = 4'b0, input bit gaps = 1'b0,
                         input bit noeof = 1'b0);
        for (int i = 0; i < n; i++) begin
            if (gaps && (i % 5 == 4)) idle(1);
            drv(8'(st + step * i), 1'b1, i == 0, (i == n - 1) && !noeof,
                i == er_at, i == dv_at, m);
        end
        idle(3);
    endtask

    task automatic clr();
        q_w.delete();
        mq_w.delete();
        q_del.delete();
        mq_del.delete();
    endtask

    initial begin
        logic [15:0] m0;

        repeat (3) @(negedge i_clk);
        chk("rst_valid", o_valid, 4'b0);
        chk("rst_delete", o_delete, 4'b0);
        chk("rst_abort", o_abort_cnt, 16'd0);
        chk("rst_flags", {o_sop, o_eop, o_empty}, 4'b0);
        i_rst_n = 1'b1;
        idle(2);

        // 64-byte frame, no lookup result
        clr();
        frame(0, 64);
        chk("f64_words", q_w.size(), 16);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("f64_data%0d", i), w(i).d, ew(0, 1, i, 64));
            chk($sformatf("f64_valid%0d", i), w(i).v, 4'b1110);
        end
        chk("f64_sop0", w(0).s, 1'b1);
        chk("f64_sop1", w(1).s, 1'b0);
        chk("f64_eop14", w(14).e, 1'b0);
        chk("f64_eop15", w(15).e, 1'b1);
        chk("f64_empty", w(15).m, 2'd0);
        chk("f64_del", q_del.size(), 0);
        chk("f64_abort", o_abort_cnt, 16'd0);

        // 66-byte frame with gaps
        clr();
        frame(0, 66, 1, -1, -1, 4'b0, 1'b1);
        chk("f66_words", q_w.size(), 17);
        chk("f66_w15", w(15).d, 32'h3C3D3E3F);
        chk("f66_last", w(16).d, 32'h40410000);
        chk("f66_eop", w(16).e, 1'b1);
        chk("f66_empty", w(16).m, 2'd2);
        chk("f66_valid", w(16).v, 4'b1110);

        // 3-byte frame, one-cycle latency and single-cycle strobe
        drv(8'hAA, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0);
        drv(8'hBB, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0);
        drv(8'hCC, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0);
        idle(1);
        chk("f3_valid", o_valid, 4'b1110);
        chk("f3_data", o_data, 32'hAABBCC00);
        chk("f3_sop_eop", {o_sop, o_eop}, 2'b11);
        chk("f3_empty", o_empty, 2'd1);
        idle(1);
        chk("f3_strobe", o_valid, 4'b0);
        idle(2);

        // Lookup prunes to port 2 after the first word
        clr();
        frame(0, 16, 1, -1, 5, 4'b0100);
        chk("dst_words", q_w.size(), 4);
        chk("dst_ndel", q_del.size(), 1);
        chk("dst_del", dl(0), 4'b1010);
        chk("dst_v0", w(0).v, 4'b1110);
        for (int i = 1; i < 4; i++)
            chk($sformatf("dst_v%0d", i), w(i).v, 4'b0100);
        chk("dst_sop1", w(1).s, 1'b0);
        chk("dst_eop", w(3).e, 1'b1);

        // Broadcast lookup keeps every channel but the source
        clr();
        frame(8'h20, 16, 1, -1, 5, 4'b1111);
        chk("bc_ndel", q_del.size(), 0);
        chk("bc_words", q_w.size(), 4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("bc_v%0d", i), w(i).v, 4'b1110);

        // PHY error on byte 20, then a good frame
        clr();
        frame(0, 32, 1, 19);
        chk("er_words", q_w.size(), 4);
        chk("er_ndel", q_del.size(), 1);
        chk("er_del", dl(0), 4'b1110);
        chk("er_abort", o_abort_cnt, 16'd1);
        clr();
        frame(8'h50, 8);
        chk("er_next_words", q_w.size(), 2);
        chk("er_next_d0", w(0).d, 32'h50515253);
        chk("er_next_sop", w(0).s, 1'b1);
        chk("er_next_eop", w(1).e, 1'b1);
        chk("er_next_ndel", q_del.size(), 0);
        chk("er_next_abort", o_abort_cnt, 16'd1);

        // New sof while a frame is open
        clr();
        frame(0, 10, 1, -1, -1, 4'b0, 1'b0, 1'b1);
        frame(8'h80, 8);
        chk("rs_words", q_w.size(), 4);
        chk("rs_ndel", q_del.size(), 1);
        chk("rs_del", dl(0), 4'b1110);
        chk("rs_abort", o_abort_cnt, 16'd2);
        chk("rs_sop1", w(1).s, 1'b0);
        chk("rs_d2", w(2).d, 32'h80818283);
        chk("rs_sop2", w(2).s, 1'b1);
        chk("rs_eop3", w(3).e, 1'b1);

        // Over-length frame on the 8-word instance
        clr();
        m0 = m_abort;
        frame(0, 40);
        chk("max_words", mq_w.size(), 8);
        chk("max_ndel", mq_del.size(), 1);
        chk("max_del", mdl(0), 4'b1110);
        chk("max_abort", m_abort, m0 + 16'd1);
        chk("max_ref_words", q_w.size(), 10);
        chk("max_ref_del", q_del.size(), 0);
        frame(8'h60, 8);
        chk("max_next_words", mq_w.size(), 10);
        chk("max_next_d", mw(8).d, 32'h60616263);
        chk("max_next_sop", mw(8).s, 1'b1);
        chk("max_next_abort", m_abort, m0 + 16'd1);

        // Reset in the middle of a frame
        clr();
        frame(0, 6, 1, -1, -1, 4'b0, 1'b0, 1'b1);
        @(negedge i_clk);
        #2 i_rst_n = 1'b0;
        #1;
        chk("mr_abort", o_abort_cnt, 16'd0);
        chk("mr_valid", o_valid, 4'b0);
        chk("mr_abort_m", m_abort, 16'd0);
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
        frame(8'h70, 8);
        chk("mr_words", q_w.size(), 3);
        chk("mr_sop", w(1).s, 1'b1);
        chk("mr_d1", w(1).d, 32'h70717273);
        chk("mr_ndel", q_del.size(), 0);
        chk("mr_abort2", o_abort_cnt, 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/frame_word_packer.md
Name: frame_word_packer

Overview:
- Packs the post-SFD byte stream from one RX port into pBYTES_PER_WORD-wide words.
- Fans each word out to every switch port except its own.
- Prunes destinations when the lookup result arrives and marks start and end of frame, with an unused-byte count on the last word.
- Aborts frames on i_rx_er, on over-length frames, and on a new frame that starts before the current one ends.
- Sits between the per-port RX FSM and the per-destination frame buffers. It is the parametrised successor of the fixed 4-byte, 3-output packer.

Parameters:
pDATA_WIDTH, 8, byte width.
pBYTES_PER_WORD, 4, bytes per output word; power of two, 2..16.
pPORT_NUM, 4, number of switch ports/output channels.
pSRC_PORT, 0, index of own port; that channel is never enabled.
pMAX_WORDS, 384, maximum words per frame before forced abort.

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
i_data  in  pDATA_WIDTH  RX byte
i_byte_valid  in  1  i_data valid this cycle
i_sof  in  1  with i_byte_valid: first byte after SFD
i_eof  in  1  with i_byte_valid: last byte of frame (FCS included)
i_rx_er  in  1  PHY error, sampled every cycle
i_dst_valid  in  1  one-cycle pulse, lookup result ready
i_dst_mask  in  pPORT_NUM  destination ports; all ones = broadcast
o_data  out  pBYTES_PER_WORD*pDATA_WIDTH  packed word, shared by all channels
o_valid  out  pPORT_NUM  per-channel word strobe
o_sop  out  1  word is first of frame
o_eop  out  1  word is last of frame
o_empty  out  $clog2(pBYTES_PER_WORD)  unused low lanes in eop word (0 otherwise)
o_delete  out  pPORT_NUM  per-channel one-cycle pulse: drop partial frame
o_abort_cnt  out  16  saturating count of aborted frames

Behaviour:
- Reset (asynchronous, i_rst_n=0): all outputs 0, state IDLE, lane counter 0, word counter 0, enable mask 0.
- Lane order: byte k of a word (k=0 first received) occupies o_data[(pBYTES_PER_WORD-k)*pDATA_WIDTH-1 -: pDATA_WIDTH]. Unused lanes in the eop word are zero.
- Enable mask at sof: all ones with bit pSRC_PORT cleared. The "sop_sent" flag per channel is cleared.
- Latency: o_valid is asserted 1 cycle after the byte that completes a word, or after the eof byte. It is a single-cycle strobe. o_data, o_sop, o_eop and o_empty are valid only while any o_valid bit is set.
- o_valid[ch] = enable_next[ch] for the emitted word, i.e. a mask update in the same cycle already applies.
- States:
  - IDLE: wait for i_byte_valid&i_sof. Then load lane 0, clear o_delete, go PACK.
  - PACK:
    - Each valid byte fills the next lane.
    - On a full word, emit. o_sop=1 on the first word of the frame, then set sop_sent for the enabled channels. Increment the word counter.
    - On an eof byte, emit the word with o_eop=1 and o_empty=pBYTES_PER_WORD-filled lanes, then go IDLE. If the eof byte also completes a full word, o_empty=0.
    - A frame of fewer than pBYTES_PER_WORD bytes gives a single word with o_sop=o_eop=1.
  - DISCARD: ignore bytes until a byte with i_eof, then go IDLE. A byte with i_sof in DISCARD starts a new frame (go PACK).
- i_dst_valid in PACK: enable <= enable & i_dst_mask & ~(1<<pSRC_PORT). Each channel that goes 1->0 with sop_sent=1 gets an o_delete pulse next cycle. A channel dropped before its sop gets no pulse. If the resulting enable is 0, go DISCARD. i_dst_valid outside PACK is ignored.
- Abort conditions in PACK, in this priority:
  - i_rx_er=1.
  - Word counter reaching pMAX_WORDS without eof.
  - i_sof with i_byte_valid (the new frame restarts in the same cycle, the new byte goes to lane 0).
- Abort action:
  - o_delete pulse next cycle on enabled channels with sop_sent; no o_valid that cycle.
  - Enable cleared; o_abort_cnt+1, saturating at 16'hFFFF.
  - Go DISCARD, or IDLE if the aborting byte had i_eof, or PACK for the sof restart.
- i_rx_er together with the eof byte: abort; no eop word is emitted.
- i_rx_er in IDLE/DISCARD: no effect.
- Gaps (i_byte_valid=0) in PACK: hold state, no emission.
- Reset mid-frame: outputs drop to 0 immediately; no o_delete is generated.

Test Plan:
- 64-byte frame 0x00..0x3F, pBYTES_PER_WORD=4, pSRC_PORT=0, no i_dst_valid -> expected:
  - 16 words, each with o_valid=4'b1110.
  - First word 0x00010203 with o_sop=1; last word 0x3C3D3E3F with o_eop=1, o_empty=0.
- 66-byte frame -> last word 0x40410000, o_eop=1, o_empty=2. A 3-byte frame 0xAA,0xBB,0xCC gives one word 0xAABBCC00 with o_sop=o_eop=1, o_empty=1.
- i_dst_valid with i_dst_mask=4'b0100 after word 2 (the first word emitted after sop) -> o_delete=4'b1010 for 1 cycle; the remaining words have o_valid=4'b0100.
- Broadcast mask 4'b1111 -> o_delete never pulses; all words have o_valid=4'b1110.
- i_rx_er asserted on byte 20 -> o_delete=4'b1110 for 1 cycle, o_abort_cnt=1, bytes ignored until eof; a following good frame is packed normally.
- pMAX_WORDS=8 with a 40-byte frame -> abort after 8 words; i_sof mid-frame -> o_delete pulse, o_abort_cnt+1, and the new frame's first word carries o_sop=1.
